// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if
//   Bundles the scoreboard's issue, query, writeback and flush signals.
//   slave  : the scoreboard itself (consumes requests, drives status)
//   master : the issue/writeback logic driving the scoreboard
//   Signals:
//     iss_valid/iss_thread/iss_dst -> iss_ready      issue handshake
//     q_thread/q_src1/q_src2/q_dst -> q_*_busy       hazard query
//     wb_valid/wb_thread/wb_dst                      release one pending write
//     flush_valid/flush_thread                       squash a thread
//     thread_idle, wb_err                            status
interface reg_scoreboard_if #(
  parameter int NTHREADS = 4,
  parameter int NREGS    = 32
);
  localparam int TID_W = $clog2(NTHREADS);
  localparam int REG_W = $clog2(NREGS);

  logic                iss_valid;
  logic [TID_W-1:0]    iss_thread;
  logic [REG_W-1:0]    iss_dst;
  logic                iss_ready;
  logic [TID_W-1:0]    q_thread;
  logic [REG_W-1:0]    q_src1;
  logic [REG_W-1:0]    q_src2;
  logic [REG_W-1:0]    q_dst;
  logic                q_src1_busy;
  logic                q_src2_busy;
  logic                q_dst_busy;
  logic                wb_valid;
  logic [TID_W-1:0]    wb_thread;
  logic [REG_W-1:0]    wb_dst;
  logic                flush_valid;
  logic [TID_W-1:0]    flush_thread;
  logic [NTHREADS-1:0] thread_idle;
  logic                wb_err;

  modport slave (
    input  iss_valid, iss_thread, iss_dst,
    output iss_ready,
    input  q_thread, q_src1, q_src2, q_dst,
    output q_src1_busy, q_src2_busy, q_dst_busy,
    input  wb_valid, wb_thread, wb_dst,
    input  flush_valid, flush_thread,
    output thread_idle, wb_err
  );

  modport master (
    output iss_valid, iss_thread, iss_dst,
    input  iss_ready,
    output q_thread, q_src1, q_src2, q_dst,
    input  q_src1_busy, q_src2_busy, q_dst_busy,
    output wb_valid, wb_thread, wb_dst,
    output flush_valid, flush_thread,
    input  thread_idle, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Per-thread register scoreboard. Issue claims a destination register
//   (in-flight writer count +1), writeback releases it (-1), flush clears a
//   whole thread. Queries report whether src1/src2/dst still have writers
//   in flight. Register 0 is hard zero and never tracked.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   sb   : reg_scoreboard_if.slave (issue, query, writeback, flush, status)
// Configuration
//   SB_WB_BYPASS_EN : when defined, a same-cycle writeback that releases the
//   last writer clears query busy combinationally, and a same-cycle
//   writeback to the issue entry frees a slot for iss_ready.
module reg_scoreboard #(
  parameter int NTHREADS = 4,
  parameter int NREGS    = 32,
  parameter int CNT_W    = 2
) (
  input  logic            clk,
  input  logic            rst,
  reg_scoreboard_if.slave sb
);
  localparam int TID_W = $clog2(NTHREADS);
  localparam int REG_W = $clog2(NREGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NTHREADS][NREGS];
  logic [CNT_W-1:0] cnt_d [NTHREADS][NREGS];
  logic             wb_err_q, wb_err_d;

  logic [CNT_W-1:0] iss_cnt, wb_cnt;
  logic             iss_flushed, wb_flushed;
  logic             wb_live, same_entry, iss_bypass, iss_fire;

  always_comb begin
    iss_cnt     = cnt_q[sb.iss_thread][sb.iss_dst];
    wb_cnt      = cnt_q[sb.wb_thread][sb.wb_dst];
    iss_flushed = sb.flush_valid && (sb.flush_thread == sb.iss_thread);
    wb_flushed  = sb.flush_valid && (sb.flush_thread == sb.wb_thread);
    wb_live     = sb.wb_valid && (sb.wb_dst != '0) && !wb_flushed;
    same_entry  = (sb.iss_thread == sb.wb_thread) && (sb.iss_dst == sb.wb_dst);
`ifdef SB_WB_BYPASS_EN
    iss_bypass  = wb_live && same_entry;
`else
    iss_bypass  = 1'b0;
`endif
    sb.iss_ready = (iss_cnt != CNT_MAX) || iss_flushed || iss_bypass;
    iss_fire     = sb.iss_valid && sb.iss_ready && (sb.iss_dst != '0) && !iss_flushed;
  end

  // Issue and writeback on the same entry cancel out; this also lets an
  // issue at max count through when a writeback frees a slot that cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (iss_fire && !(wb_live && same_entry))
      cnt_d[sb.iss_thread][sb.iss_dst] = iss_cnt + 1'b1;
    if (wb_live && !(iss_fire && same_entry) && (wb_cnt != '0))
      cnt_d[sb.wb_thread][sb.wb_dst] = wb_cnt - 1'b1;
    if (sb.flush_valid) begin
      for (int unsigned r = 0; r < NREGS; r++)
        cnt_d[sb.flush_thread][r] = '0;
    end
    wb_err_d = wb_err_q || (wb_live && !(iss_fire && same_entry) && (wb_cnt == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned t = 0; t < NTHREADS; t++)
        for (int unsigned r = 0; r < NREGS; r++)
          cnt_q[t][r] <= '0;
      wb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end

  logic [CNT_W-1:0] src1_cnt, src2_cnt, dst_cnt;

  always_comb begin
    src1_cnt = cnt_q[sb.q_thread][sb.q_src1];
    src2_cnt = cnt_q[sb.q_thread][sb.q_src2];
    dst_cnt  = cnt_q[sb.q_thread][sb.q_dst];
`ifdef SB_WB_BYPASS_EN
    // A writeback retiring the last writer releases the register this cycle.
    sb.q_src1_busy = (src1_cnt != '0) && !(wb_live && (sb.wb_thread == sb.q_thread) &&
                     (sb.wb_dst == sb.q_src1) && (src1_cnt == CNT_W'(1)));
    sb.q_src2_busy = (src2_cnt != '0) && !(wb_live && (sb.wb_thread == sb.q_thread) &&
                     (sb.wb_dst == sb.q_src2) && (src2_cnt == CNT_W'(1)));
    sb.q_dst_busy  = (dst_cnt  != '0) && !(wb_live && (sb.wb_thread == sb.q_thread) &&
                     (sb.wb_dst == sb.q_dst)  && (dst_cnt  == CNT_W'(1)));
`else
    sb.q_src1_busy = (src1_cnt != '0);
    sb.q_src2_busy = (src2_cnt != '0);
    sb.q_dst_busy  = (dst_cnt  != '0);
`endif
  end

  logic [NTHREADS-1:0] idle;

  always_comb begin
    idle = '1;
    for (int unsigned t = 0; t < NTHREADS; t++)
      for (int unsigned r = 0; r < NREGS; r++)
        if (cnt_q[t][r] != '0) idle[t] = 1'b0;
    sb.thread_idle = idle;
    sb.wb_err      = wb_err_q;
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NTHREADS(4), .NREGS(32)) sb_if ();

  reg_scoreboard #(.NTHREADS(4), .NREGS(32), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  typedef enum int {S_RDY, S_B1, S_B2, S_BD, S_IDLE, S_ERR} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef SB_WB_BYPASS_EN
  localparam logic [31:0] BYP_BUSY = 32'd0;
`else
  localparam logic [31:0] BYP_BUSY = 32'd1;
`endif

  function automatic logic [31:0] sample(input sel_e s);
    case (s)
      S_RDY:   return {31'b0, sb_if.iss_ready};
      S_B1:    return {31'b0, sb_if.q_src1_busy};
      S_B2:    return {31'b0, sb_if.q_src2_busy};
      S_BD:    return {31'b0, sb_if.q_dst_busy};
      S_IDLE:  return {28'b0, sb_if.thread_idle};
      default: return {31'b0, sb_if.wb_err};
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations queued for this cycle.
  chk_t        mc;
  logic [31:0] act;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mc  = exp_q.pop_front();
      act = sample(mc.sel);
      checks++;
      if (act !== mc.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", mc.name, act, mc.exp);
      end
    end
  end

  task automatic expect_v(input string n, input sel_e s, input logic [31:0] v);
    chk_t c;
    c.name = n; c.sel = s; c.exp = v;
    exp_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    sb_if.iss_valid   = 1'b0;
    sb_if.wb_valid    = 1'b0;
    sb_if.flush_valid = 1'b0;
  endtask

  task automatic iss(input int t, input int d);
    sb_if.iss_valid = 1'b1; sb_if.iss_thread = 2'(t); sb_if.iss_dst = 5'(d);
  endtask

  task automatic wb(input int t, input int d);
    sb_if.wb_valid = 1'b1; sb_if.wb_thread = 2'(t); sb_if.wb_dst = 5'(d);
  endtask

  task automatic qry(input int t, input int s1, input int s2, input int d);
    sb_if.q_thread = 2'(t); sb_if.q_src1 = 5'(s1); sb_if.q_src2 = 5'(s2); sb_if.q_dst = 5'(d);
  endtask

  initial begin
    rst = 1'b0;
    clr();
    sb_if.iss_thread = '0; sb_if.iss_dst = 5'd5;
    sb_if.wb_thread = '0; sb_if.wb_dst = '0; sb_if.flush_thread = '0;
    qry(0, 5, 0, 0);
    // Reset state
    expect_v("rst_busy1", S_B1, 0);
    expect_v("rst_ready", S_RDY, 1);
    expect_v("rst_idle", S_IDLE, 32'hF);
    expect_v("rst_err", S_ERR, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Basic issue / query / writeback
    iss(0, 5); expect_v("t2_ready", S_RDY, 1); step();
    clr(); qry(0, 5, 0, 0);
    expect_v("t2_busy", S_B1, 1); expect_v("t2_idle", S_IDLE, 32'hE); step();
    qry(1, 5, 0, 0); wb(0, 5); expect_v("t2_other_thread", S_B1, 0); step();
    clr(); qry(0, 5, 0, 0);
    expect_v("t2_released", S_B1, 0); expect_v("t2_idle_back", S_IDLE, 32'hF); step();

    // Register 0 is never tracked
    iss(2, 0); sb_if.iss_dst = 5'd0; expect_v("t5_r0_ready", S_RDY, 1); step();
    clr(); qry(2, 0, 0, 0);
    expect_v("t5_r0_busy", S_BD, 0); expect_v("t5_idle", S_IDLE, 32'hF);
    wb(2, 0); step();
    clr(); expect_v("t5_r0_wb_err", S_ERR, 0); step();

    // Same-cycle issue + writeback on one entry
    iss(1, 3); step();
    iss(1, 3); wb(1, 3); expect_v("t4_ready", S_RDY, 1); step();
    clr(); qry(1, 0, 3, 0); expect_v("t4_net_zero", S_B2, 1); step();
    wb(1, 3); qry(1, 0, 3, 0); expect_v("t4_wb_same_cycle", S_B2, BYP_BUSY); step();
    clr(); expect_v("t4_after_wb", S_B2, 0); expect_v("t4_err", S_ERR, 0); step();

    // Saturation, drop, and sticky wb_err
    qry(0, 0, 0, 7); iss(0, 7);
    expect_v("t3_rdy_a", S_RDY, 1); step();
    expect_v("t3_rdy_b", S_RDY, 1); step();
    expect_v("t3_rdy_c", S_RDY, 1); step();
    expect_v("t3_full", S_RDY, 0); expect_v("t3_busy_full", S_BD, 1); step();
    clr(); expect_v("t3_dropped_rdy", S_RDY, 0); expect_v("t3_dropped_busy", S_BD, 1); step();
    for (int k = 1; k <= 3; k++) begin
      wb(0, 7); step();
      clr();
      expect_v("t3_wb_busy", S_BD, (k < 3) ? 32'd1 : 32'd0);
      expect_v("t3_wb_err", S_ERR, 0);
      if (k == 1) expect_v("t3_rdy_after_wb", S_RDY, 1);
      step();
    end
    wb(0, 7); step();
    clr(); expect_v("t3_err_set", S_ERR, 1); step();
    step(); expect_v("t3_err_sticky", S_ERR, 1); step();

    // Asynchronous reset clears the sticky error
    rst = 1'b0; #1;
    expect_v("rst2_err", S_ERR, 0); expect_v("rst2_idle", S_IDLE, 32'hF); step();
    rst = 1'b1;

    // Flush
    iss(0, 4); step(); step();
    iss(1, 4); step();
    iss(0, 4); wb(0, 9); sb_if.flush_valid = 1'b1; sb_if.flush_thread = 2'd0;
    expect_v("t6_pre_idle", S_IDLE, 32'hC); expect_v("t6_ready", S_RDY, 1); step();
    clr(); qry(0, 0, 0, 4);
    expect_v("t6_t0_busy", S_BD, 0); expect_v("t6_idle", S_IDLE, 32'hD);
    expect_v("t6_err", S_ERR, 0); step();
    qry(1, 0, 0, 4); expect_v("t6_t1_busy", S_BD, 1); step();

    step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
